// File: rtl/truth_table_sweeper.sv
// Steps a 3-input gate through all eight input rows, samples its output after a
// settle period per row and reports the assembled MSB-first truth table.
module truth_table_sweeper #(
    parameter int         SETTLE_CYCLES = 4,
    parameter logic [7:0] EXPECTED      = 8'hC0,
    parameter int         CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       gate_out,
    output logic       gate_in1,
    output logic       gate_in2,
    output logic       gate_in3,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_out,
    output logic       match
);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state, state_nxt;
    logic [2:0]       row, row_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [7:0]       shift_q, shift_nxt;
    logic [7:0]       table_q, table_nxt;
    logic             match_q, match_nxt;
    logic [7:0]       shifted;
    logic             sample;

    assign shifted = {shift_q[6:0], gate_out};
    assign sample  = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            row     <= 3'd0;
            cnt     <= '0;
            shift_q <= 8'h00;
            table_q <= 8'h00;
            match_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            row     <= row_nxt;
            cnt     <= cnt_nxt;
            shift_q <= shift_nxt;
            table_q <= table_nxt;
            match_q <= match_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        row_nxt   = row;
        cnt_nxt   = cnt;
        shift_nxt = shift_q;
        table_nxt = table_q;
        match_nxt = match_q;
        case (state)
            IDLE: begin
                // abort has priority over a simultaneous start
                if (start && !abort) begin
                    state_nxt = RUN;
                    row_nxt   = 3'd0;
                    cnt_nxt   = '0;
                    shift_nxt = 8'h00;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                    row_nxt   = 3'd0;
                    cnt_nxt   = '0;
                    shift_nxt = 8'h00;
                end else if (sample) begin
                    shift_nxt = shifted;
                    cnt_nxt   = '0;
                    if (row == 3'd7) begin
                        // publish on the final sample edge so table_out is valid with done
                        state_nxt = FINISH;
                        table_nxt = shifted;
                        match_nxt = (shifted == EXPECTED);
                    end else begin
                        row_nxt = row + 3'd1;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            FINISH: begin
                state_nxt = IDLE;
                row_nxt   = 3'd0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign {gate_in1, gate_in2, gate_in3} = (state == RUN) ? row : 3'b000;
    assign busy      = (state == RUN);
    assign done      = (state == FINISH);
    assign table_out = table_q;
    assign match     = match_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper: one instance with 4-cycle settle,
// one with single-cycle settle, each driving a behavioural gate model.
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start4 = 1'b0, start1 = 1'b0, abort = 1'b0;
    logic go4, go1;
    logic [2:0] gi4, gi1;
    logic busy4, busy1, done4, done1, match4, match1;
    logic [7:0] tout4, tout1;
    int mode4 = 0, mode1 = 0;
    int n_cmp = 0, n_bad = 0;
    logic [7:0] q4[$], q1[$];

    always #5 clk = ~clk;

    truth_table_sweeper #(.SETTLE_CYCLES(4), .EXPECTED(8'hC0), .CNT_W(8)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .abort(abort), .gate_out(go4),
        .gate_in1(gi4[2]), .gate_in2(gi4[1]), .gate_in3(gi4[0]),
        .busy(busy4), .done(done4), .table_out(tout4), .match(match4));

    truth_table_sweeper #(.SETTLE_CYCLES(1), .EXPECTED(8'hC0), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort), .gate_out(go1),
        .gate_in1(gi1[2]), .gate_in2(gi1[1]), .gate_in3(gi1[0]),
        .busy(busy1), .done(done1), .table_out(tout1), .match(match1));

    // mode 0: ~a&~b, mode 1: constant 1, mode 2: a&b&c
    function automatic logic gate_f(input int mode, input logic [2:0] r);
        case (mode)
            0:       return ~r[2] & ~r[1];
            1:       return 1'b1;
            default: return r[2] & r[1] & r[0];
        endcase
    endfunction

    function automatic logic [7:0] model_table(input int mode);
        logic [7:0] t = 8'h00;
        for (int r = 0; r < 8; r++) t = {t[6:0], gate_f(mode, 3'(r))};
        return t;
    endfunction

    assign go4 = gate_f(mode4, gi4);
    assign go1 = gate_f(mode1, gi1);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done4 === 1'b1) begin
            if (q4.size() == 0) chk("spurious_done4", 1, 0);
            else begin
                logic [7:0] e;
                e = q4.pop_front();
                chk("table4", tout4, e);
                chk("match4", match4, e == 8'hC0);
            end
        end
        if (done1 === 1'b1) begin
            if (q1.size() == 0) chk("spurious_done1", 1, 0);
            else begin
                logic [7:0] e;
                e = q1.pop_front();
                chk("table1", tout1, e);
                chk("match1", match1, e == 8'hC0);
            end
        end
    end

    task automatic kick(input bit which);
        @(negedge clk);
        if (which) start1 = 1'b1; else start4 = 1'b1;
        @(posedge clk);
        #1;
        if (which) start1 = 1'b0; else start4 = 1'b0;
    endtask

    // Called just after the acceptance edge; checks rows/busy every cycle and
    // returns done latency (negedge index), or -1 when stopped early at stop_at.
    task automatic watch(input bit which, input int s, input int stop_at,
                         input bit do_abort, output int lat, output int bad);
        lat = -2;
        bad = 0;
        for (int c = 0; c <= 8 * s + 8; c++) begin
            logic [2:0] r;
            logic b, d;
            @(negedge clk);
            r = which ? gi1 : gi4;
            b = which ? busy1 : busy4;
            d = which ? done1 : done4;
            if (d) begin
                lat = c;
                if (b) bad++;
                break;
            end
            if (c < 8 * s) begin
                if (!b || r != 3'(c / s)) bad++;
            end else bad++;
            if (c == stop_at) begin
                if (do_abort) abort = 1'b1;
                lat = -1;
                break;
            end
        end
    endtask

    initial begin
        int lat, bad;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy4", busy4, 0);
        chk("rst_done4", done4, 0);
        chk("rst_gin4", gi4, 0);
        chk("rst_table4", tout4, 8'h00);
        chk("rst_match4", match4, 0);
        chk("rst_busy1", busy1, 0);
        chk("rst_table1", tout1, 8'h00);
        rst = 1'b0;

        // S=4 sweeps with three gate models
        for (int k = 0; k < 3; k++) begin
            int m;
            m = (k == 2) ? 0 : k + 1;
            mode4 = m;
            q4.push_back(model_table(m));
            kick(1'b0);
            watch(1'b0, 4, -1, 1'b0, lat, bad);
            chk("lat4", lat, 32);
            chk("rows4", bad, 0);
            @(negedge clk);
            chk("idle_after4", busy4 | done4, 0);
        end
        chk("model_c0", model_table(0), 8'hC0);

        // S=1 sweeps
        for (int m = 0; m < 3; m += 2) begin
            mode1 = m;
            q1.push_back(model_table(m));
            kick(1'b1);
            watch(1'b1, 1, -1, 1'b0, lat, bad);
            chk("lat1", lat, 8);
            chk("rows1", bad, 0);
            @(negedge clk);
        end

        // abort during row 5; prior passing result must survive
        mode4 = 1;
        kick(1'b0);
        watch(1'b0, 4, 21, 1'b1, lat, bad);
        chk("abort_reached", lat, -1);
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy4, 0);
        chk("abort_gin", gi4, 0);
        chk("abort_done", done4, 0);
        chk("abort_table", tout4, 8'hC0);
        chk("abort_match", match4, 1);
        repeat (40) @(negedge clk);
        chk("abort_stays_idle", busy4, 0);

        // start held high: back-to-back sweeps with one idle cycle between
        mode4 = 2;
        q4.push_back(model_table(2));
        q4.push_back(model_table(2));
        @(negedge clk);
        start4 = 1'b1;
        @(posedge clk);
        watch(1'b0, 4, -1, 1'b0, lat, bad);
        chk("held_lat_a", lat, 32);
        chk("held_rows_a", bad, 0);
        @(negedge clk);
        chk("held_gap_busy", busy4, 0);
        chk("held_gap_done", done4, 0);
        @(posedge clk);
        watch(1'b0, 4, -1, 1'b0, lat, bad);
        start4 = 1'b0;
        chk("held_lat_b", lat, 32);
        chk("held_rows_b", bad, 0);
        repeat (3) @(negedge clk);
        chk("held_no_third", busy4, 0);

        // reset during row 3, then start+abort together while idle
        mode4 = 0;
        kick(1'b0);
        watch(1'b0, 4, 13, 1'b0, lat, bad);
        chk("rst_reached", lat, -1);
        rst = 1'b1;
        start4 = 1'b1;
        abort = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("mrst_busy", busy4, 0);
        chk("mrst_done", done4, 0);
        chk("mrst_gin", gi4, 0);
        chk("mrst_table", tout4, 8'h00);
        chk("mrst_match", match4, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("start_abort_ignored", busy4, 0);
        q4.push_back(model_table(0));
        abort = 1'b0;
        @(posedge clk);
        #1 start4 = 1'b0;
        watch(1'b0, 4, -1, 1'b0, lat, bad);
        chk("post_rst_lat", lat, 32);
        chk("post_rst_rows", bad, 0);

        repeat (4) @(negedge clk);
        chk("q4_drained", q4.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequencer that exercises one external 3-input combinational gate (the in1/in2/in3 -> out netlists of the 3-input case library) across all 8 input rows.
- Drives each row, waits a programmable settle time, samples the gate output, and assembles an 8-bit truth-table word.
- Compares the word against an expected hex truth table and reports pass/fail.
- Sits between a test/config master (start/abort) and a single gate instance.

Parameters:
- SETTLE_CYCLES, 4, cycles each row is held before sampling; legal range 1..255.
- EXPECTED, 8'hC0, expected truth table, MSB-first: bit 7 = row 3'b000, bit 0 = row 3'b111.
- CNT_W, 8, settle counter width; must hold SETTLE_CYCLES-1.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  level-sampled request to begin a sweep; accepted only in IDLE.
- abort  input  1  cancels a sweep in progress.
- gate_out  input  1  output of the gate under sweep.
- gate_in1  output  1  gate input, MSB of row index.
- gate_in2  output  1  gate input, middle bit of row index.
- gate_in3  output  1  gate input, LSB of row index.
- busy  output  1  high while a sweep is running.
- done  output  1  one-cycle pulse when a sweep completes.
- table_out  output  8  last completed truth table, MSB-first.
- match  output  1  table_out == EXPECTED, valid from done onward.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; row=0; cnt=0; internal shift table=0.
  - Outputs: gate_in1/2/3=0, busy=0, done=0, table_out=8'h00, match=0.
  - Reset mid-sweep discards all progress with no done pulse.
- States: IDLE, RUN, FINISH.
- IDLE:
  - gate_in{1,2,3} = 000.
  - If start=1 and abort=0 at edge E0: go to RUN with row=0, cnt=0, busy=1, shift table cleared.
  - If start and abort are both high in IDLE: abort wins and start is ignored.
- RUN:
  - {gate_in1,gate_in2,gate_in3} = row, registered. Row k is driven on the outputs from edge E0+k*S through edge E0+(k+1)*S, where S=SETTLE_CYCLES.
  - cnt increments each cycle.
  - At the edge where cnt==S-1: shift gate_out into the table LSB (table <= {table[6:0], gate_out}), cnt<=0.
  - If row==7 at that edge: go to FINISH. Otherwise row<=row+1.
  - Row 000 is therefore shifted in first and ends in bit 7.
- FINISH (one cycle, entered at edge E0+8*S):
  - table_out <= table; match <= (table==EXPECTED); done=1; busy=0; gate inputs return to 000.
  - At the next edge: IDLE, done=0.
- Latency: done is high during the cycle after edge E0+8*S. Total 8*S+1 cycles from start acceptance to done low. With S=1, one row per cycle.
- start while busy or in FINISH: ignored, not queued. A new start is accepted from IDLE only, i.e. no earlier than the cycle after done.
- abort=1 in RUN:
  - Next edge: IDLE, busy=0, gate inputs=000, shift table cleared.
  - table_out and match keep their previous completed values. No done pulse.
- abort in FINISH is ignored; the completion stands. abort in IDLE has no effect.
- table_out and match change only in FINISH or on reset. They hold stable between sweeps and are never updated partially.
- gate_out is sampled only at the sample edges; its value at any other time is don't-care.

Test Plan:
- S=4, EXPECTED=8'hC0, gate modelled as out=~in1&~in2 (rows 000,001 ->1); pulse start -> rows 0..7 each held 4 cycles; done at cycle 33 after start; table_out=8'hC0, match=1, busy low with done.
- Same config, gate modelled as constant 1 -> table_out=8'hFF, match=0; then a second sweep with gate=in1&in2&in3 -> table_out=8'h01, match=0.
- S=1 -> gate inputs step 000..111 on consecutive cycles; done 9 cycles after start acceptance; table matches the modelled gate.
- abort asserted during row 5 after a prior passing sweep -> next cycle busy=0, inputs=000, no done; table_out stays 8'hC0, match stays 1.
- start held high continuously -> sweeps back-to-back with one IDLE cycle between done and the next busy; start pulses mid-sweep are ignored (row sequence undisturbed).
- rst asserted during row 3, then also start=1 and abort=1 together in IDLE -> all outputs 0 after reset; no sweep starts while abort is high; a later start alone begins a sweep normally.
